// File: rtl/sys_array_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : sys_array_axis_packetizer
// Purpose  : Passes a programmed number of AXI-Stream beats from the adder
//            FIFO to the write master. It tags the final beat with tlast and
//            pulses ctrl_done once the tagged beat has left on m_axis.
// Ports    : aclk, areset            - clock, asynchronous active-high reset
//            ctrl_start/xfer_beats   - start pulse and beat count
//            ctrl_done/ctrl_busy     - completion pulse, busy flag
//            s_axis_*                - upstream stream (tready registered)
//            m_axis_*                - downstream stream (2-entry skid buffer,
//                                      all outputs registered)
//            tlast_err               - sticky upstream tlast mismatch flag
// Options  : SYS_ARRAY_PKT_TLAST_CHECK_EN - enables the tlast_err checker.
//            Without it, tlast_err is 0 and s_axis_tlast is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sys_array_axis_packetizer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_beats,
  output logic                            ctrl_done,
  output logic                            ctrl_busy,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            tlast_err
);

  localparam int C_KEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [C_XFER_SIZE_WIDTH-1:0]   r_beats_left;
  logic                           r_s_ready;

  // Output stage (drives m_axis) and skid stage behind it.
  logic                           r_out_valid;
  logic [C_AXIS_TDATA_WIDTH-1:0]  r_out_data;
  logic [C_KEEP_WIDTH-1:0]        r_out_keep;
  logic                           r_out_last;
  logic                           r_skid_valid;
  logic [C_AXIS_TDATA_WIDTH-1:0]  r_skid_data;
  logic [C_KEEP_WIDTH-1:0]        r_skid_keep;
  logic                           r_skid_last;

  logic                           w_in_fire;
  logic                           w_out_fire;
  logic                           w_in_last;
  logic                           w_start_ok;
  logic [1:0]                     w_fill;
  logic [1:0]                     w_fill_next;

  assign w_in_fire   = s_axis_tvalid & r_s_ready;
  assign w_out_fire  = r_out_valid & m_axis_tready;
  // The beat taking the counter from 1 to 0 is the tagged last beat.
  assign w_in_last   = (r_beats_left == C_XFER_SIZE_WIDTH'(1));
  assign w_start_ok  = (r_state == S_IDLE) & ctrl_start;
  assign w_fill      = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
  assign w_fill_next = w_fill + {1'b0, w_in_fire} - {1'b0, w_out_fire};

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ctrl_start) begin
          w_state_next = (ctrl_xfer_beats == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_in_fire && w_in_last) begin
          w_state_next = S_DRAIN;
        end
      end
      // Only the tagged beat can carry r_out_last once RUN has ended.
      S_DRAIN: begin
        if (w_out_fire && r_out_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign ctrl_done = (r_state == S_DONE);
  assign ctrl_busy = (r_state == S_RUN) || (r_state == S_DRAIN);

  // --------------------------------------------------------------------------
  // Remaining-beat counter and registered upstream ready
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beats_left <= '0;
    end else if (w_start_ok) begin
      r_beats_left <= ctrl_xfer_beats;
    end else if (w_in_fire) begin
      r_beats_left <= r_beats_left - C_XFER_SIZE_WIDTH'(1);
    end
  end

  // Ready for next cycle only if at least one buffer slot stays free; at most
  // one beat can arrive per cycle, so the skid buffer never overflows.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= (w_state_next == S_RUN) && (w_fill_next < 2'd2);
    end
  end

  assign s_axis_tready = r_s_ready;

  // --------------------------------------------------------------------------
  // Two-entry skid buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_keep  <= '0;
      r_skid_last  <= 1'b0;
    end else if (w_out_fire || !r_out_valid) begin
      if (r_skid_valid) begin
        // Oldest beat moves from skid to output; a new beat refills skid.
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_keep   <= r_skid_keep;
        r_out_last   <= r_skid_last;
        r_skid_valid <= w_in_fire;
        if (w_in_fire) begin
          r_skid_data <= s_axis_tdata;
          r_skid_keep <= s_axis_tkeep;
          r_skid_last <= w_in_last;
        end
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out_data <= s_axis_tdata;
          r_out_keep <= s_axis_tkeep;
          r_out_last <= w_in_last;
        end
      end
    end else if (w_in_fire) begin
      // Output stalled: park the incoming beat in the skid slot.
      r_skid_valid <= 1'b1;
      r_skid_data  <= s_axis_tdata;
      r_skid_keep  <= s_axis_tkeep;
      r_skid_last  <= w_in_last;
    end
  end

  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = r_out_keep;
  assign m_axis_tlast  = r_out_last;

  // --------------------------------------------------------------------------
  // Optional upstream tlast checker
  // --------------------------------------------------------------------------
`ifdef SYS_ARRAY_PKT_TLAST_CHECK_EN
  logic r_tlast_err;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tlast_err <= 1'b0;
    end else if (w_start_ok) begin
      r_tlast_err <= 1'b0;
    end else if (w_in_fire && (s_axis_tlast != w_in_last)) begin
      r_tlast_err <= 1'b1;
    end
  end

  assign tlast_err = r_tlast_err;
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign tlast_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_array_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_array_axis_packetizer
// Purpose  : Directed self-checking bench for sys_array_axis_packetizer.
//            Build with SYS_ARRAY_PKT_TLAST_CHECK_EN to exercise the checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_axis_packetizer;

  localparam int DW = 32;
  localparam int XW = 4;
  localparam int KW = DW / 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [XW-1:0] ctrl_xfer_beats = '0;
  logic          ctrl_done;
  logic          ctrl_busy;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          tlast_err;

  always #5 aclk = ~aclk;

  sys_array_axis_packetizer #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_XFER_SIZE_WIDTH  (XW)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .ctrl_start      (ctrl_start),
    .ctrl_xfer_beats (ctrl_xfer_beats),
    .ctrl_done       (ctrl_done),
    .ctrl_busy       (ctrl_busy),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .tlast_err       (tlast_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Per-run observation record
  int cyc, src_idx, tlast_at, xfer_beats;
  int done_cnt, done_cyc, first_in_cyc, first_out_cyc, err_cyc;
  int ready_hi, ready_drop, stall_err, stall_seen, mvalid_seen;
  bit tog_ready = 1'b0;
  logic [DW-1:0] out_data[$];
  logic [KW-1:0] out_keep[$];
  logic          out_last[$];
  int            out_cyc[$];
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  function automatic logic [KW-1:0] keep_of(input int i);
    logic [31:0] v;
    v = i;
    return v[3:0] ^ 4'hA;
  endfunction

  task automatic drive_src();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(src_idx);
    s_axis_tkeep  = keep_of(src_idx);
    s_axis_tlast  = (src_idx == tlast_at);
  endtask

  task automatic clear_mon();
    cyc = 0; src_idx = 0; done_cnt = 0; done_cyc = -1;
    first_in_cyc = -1; first_out_cyc = -1; err_cyc = -1;
    ready_hi = 0; ready_drop = 0; stall_err = 0; stall_seen = 0; mvalid_seen = 0;
    prev_stall = 1'b0; prev_data = '0; prev_keep = '0; prev_last = 1'b0;
    out_data.delete(); out_keep.delete(); out_last.delete(); out_cyc.delete();
  endtask

  // One clock: observe at the falling edge, update stimulus just after rising.
  task automatic step();
    logic consumed;
    @(negedge aclk);
    cyc++;
    if (ctrl_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (tlast_err && err_cyc < 0) err_cyc = cyc;
    if (m_axis_tvalid) mvalid_seen++;
    if (prev_stall) begin
      stall_seen++;
      if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tkeep !== prev_keep ||
          m_axis_tlast !== prev_last) stall_err++;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data = m_axis_tdata; prev_keep = m_axis_tkeep; prev_last = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      out_data.push_back(m_axis_tdata);
      out_keep.push_back(m_axis_tkeep);
      out_last.push_back(m_axis_tlast);
      out_cyc.push_back(cyc);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (s_axis_tready) ready_hi++;
    if (ctrl_busy && !s_axis_tready && src_idx < xfer_beats) ready_drop++;
    consumed = s_axis_tvalid && s_axis_tready;
    if (consumed && first_in_cyc < 0) first_in_cyc = cyc;
    @(posedge aclk);
    #1;
    if (consumed) src_idx++;
    ctrl_start = 1'b0;
    if (tog_ready) m_axis_tready = ~m_axis_tready;
    drive_src();
  endtask

  task automatic kick(input int b);
    clear_mon();
    xfer_beats      = b;
    tlast_at        = b - 1;
    ctrl_start      = 1'b1;
    ctrl_xfer_beats = XW'(b);
    drive_src();
  endtask

  // Bounded wait for ctrl_done, plus a few cycles to catch a second pulse.
  task automatic run(input int maxc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      step();
      k++;
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    n_cmp++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, ctrl_done, ctrl_busy, tlast_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, ctrl_done, ctrl_busy, tlast_err});
    end
    areset = 1'b0;
  endtask

  task automatic test_basic();
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(4);
    run(50);
    n_cmp++; if (out_data.size() !== 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", out_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if ({out_data[i], out_keep[i], out_last[i]} !== {DW'(i), keep_of(i), (i == 3)}) begin
          n_bad++;
          $display("FAIL basic_beat%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b", i,
                   out_data[i], out_keep[i], out_last[i], DW'(i), keep_of(i), (i == 3));
        end
      end
    end
    if (out_cyc.size() == 4) begin
      n_cmp++; if (out_cyc[3] - out_cyc[0] !== 3) begin n_bad++; $display("FAIL basic_consecutive: got span %0d want 3", out_cyc[3] - out_cyc[0]); end
    end
    n_cmp++; if (first_in_cyc !== 2) begin n_bad++; $display("FAIL basic_first_accept: got cyc %0d want 2", first_in_cyc); end
    n_cmp++; if (first_out_cyc !== 3) begin n_bad++; $display("FAIL basic_latency: got cyc %0d want 3", first_out_cyc); end
    n_cmp++; if (ready_hi !== 4) begin n_bad++; $display("FAIL basic_tready_cycles: got %0d want 4", ready_hi); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== 7) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 7", done_cyc); end
  endtask

  task automatic test_zero();
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(0);
    run(20);
    n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (ready_hi !== 0) begin n_bad++; $display("FAIL zero_tready: got %0d want 0", ready_hi); end
    n_cmp++; if (mvalid_seen !== 0) begin n_bad++; $display("FAIL zero_mvalid: got %0d want 0", mvalid_seen); end
  endtask

  task automatic test_stall();
    m_axis_tready = 1'b1; tog_ready = 1'b1;
    kick(8);
    run(100);
    tog_ready = 1'b0; m_axis_tready = 1'b1;
    n_cmp++; if (out_data.size() !== 8) begin n_bad++; $display("FAIL stall_count: got %0d want 8", out_data.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if ({out_data[i], out_keep[i], out_last[i]} !== {DW'(i), keep_of(i), (i == 7)}) begin
          n_bad++;
          $display("FAIL stall_beat%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b", i,
                   out_data[i], out_keep[i], out_last[i], DW'(i), keep_of(i), (i == 7));
        end
      end
    end
    n_cmp++; if (stall_seen == 0) begin n_bad++; $display("FAIL stall_occurred: got %0d stalls want >0", stall_seen); end
    n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
    n_cmp++; if (ready_drop == 0) begin n_bad++; $display("FAIL stall_tready_drop: got %0d want >0", ready_drop); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(6);
    step();
    step();
    ctrl_start = 1'b1;
    ctrl_xfer_beats = XW'(2);
    run(60);
    n_cmp++; if (out_data.size() !== 6) begin n_bad++; $display("FAIL restart_count: got %0d want 6", out_data.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if ({out_data[i], out_last[i]} !== {DW'(i), (i == 5)}) begin
          n_bad++;
          $display("FAIL restart_beat%0d: got d=%h l=%b want d=%h l=%b", i, out_data[i], out_last[i], DW'(i), (i == 5));
        end
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== 9) begin n_bad++; $display("FAIL restart_done_cycle: got %0d want 9", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int k;
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(5);
    k = 0;
    while (out_data.size() < 2 && k < 40) begin
      step();
      k++;
    end
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL midreset_pre_valid: got %b want 1", m_axis_tvalid); end
    #1 areset = 1'b1;
    #1;
    n_cmp++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, ctrl_done, ctrl_busy, tlast_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL midreset_async: got %b want 000000",
               {s_axis_tready, m_axis_tvalid, m_axis_tlast, ctrl_done, ctrl_busy, tlast_err});
    end
    @(posedge aclk);
    #1 areset = 1'b0;
    clear_mon();
    xfer_beats = 0;
    repeat (4) step();
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt); end
    n_cmp++; if (mvalid_seen !== 0) begin n_bad++; $display("FAIL midreset_flushed: got %0d valid cycles want 0", mvalid_seen); end
    kick(3);
    run(40);
    n_cmp++; if (out_data.size() !== 3) begin n_bad++; $display("FAIL midreset_fresh_count: got %0d want 3", out_data.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if ({out_data[i], out_last[i]} !== {DW'(i), (i == 2)}) begin
          n_bad++;
          $display("FAIL midreset_beat%0d: got d=%h l=%b want d=%h l=%b", i, out_data[i], out_last[i], DW'(i), (i == 2));
        end
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL midreset_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_max_count();
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(15);
    run(80);
    n_cmp++; if (out_data.size() !== 15) begin n_bad++; $display("FAIL max_count: got %0d want 15", out_data.size()); end
    for (int i = 0; i < 15; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if ({out_data[i], out_last[i]} !== {DW'(i), (i == 14)}) begin
          n_bad++;
          $display("FAIL max_beat%0d: got d=%h l=%b want d=%h l=%b", i, out_data[i], out_last[i], DW'(i), (i == 14));
        end
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL max_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_tlast_check();
    m_axis_tready = 1'b1; tog_ready = 1'b0;
    kick(4);
    tlast_at = 1;
    drive_src();
    run(50);
    n_cmp++; if (out_data.size() !== 4) begin n_bad++; $display("FAIL tlast_count: got %0d want 4", out_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < out_data.size()) begin
        n_cmp++;
        if (out_last[i] !== (i == 3)) begin
          n_bad++;
          $display("FAIL tlast_mlast%0d: got %b want %b", i, out_last[i], (i == 3));
        end
      end
    end
`ifdef SYS_ARRAY_PKT_TLAST_CHECK_EN
    n_cmp++; if (err_cyc !== 4) begin n_bad++; $display("FAIL tlast_err_cycle: got %0d want 4", err_cyc); end
    n_cmp++; if (tlast_err !== 1'b1) begin n_bad++; $display("FAIL tlast_err_sticky: got %b want 1", tlast_err); end
    kick(1);
    run(30);
    n_cmp++; if (tlast_err !== 1'b0) begin n_bad++; $display("FAIL tlast_err_clear: got %b want 0", tlast_err); end
    n_cmp++; if (out_data.size() !== 1) begin n_bad++; $display("FAIL tlast_single_count: got %0d want 1", out_data.size()); end
`else
    n_cmp++; if (err_cyc !== -1) begin n_bad++; $display("FAIL tlast_err_disabled: got first cyc %0d want never", err_cyc); end
`endif
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL tlast_done_count: got %0d want 1", done_cnt); end
  endtask

  initial begin
    clear_mon();
    xfer_beats = 0;
    tlast_at = -1;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_max_count();
    test_tlast_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
